// File: rtl/io_input_debouncer.sv
// Switch/key input conditioner: 2-flop synchronizers, per-channel debounce counters,
// sticky key-press flags with clear-on-read, and a switch-change event counter.
module io_input_debouncer #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_KEY-1:0] key_raw,
    input  logic             rd_en,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic [N_SW-1:0]  sw_stable,
    output logic [N_KEY-1:0] key_stable,
    output logic [N_KEY-1:0] key_pending,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
    logic [N_KEY-1:0] key_s1_q, key_s2_q;
    logic [N_KEY-1:0] key_sync;

    logic [CW-1:0]    sw_cnt_q  [N_SW];
    logic [CW-1:0]    sw_cnt_d  [N_SW];
    logic [CW-1:0]    key_cnt_q [N_KEY];
    logic [CW-1:0]    key_cnt_d [N_KEY];

    logic [N_SW-1:0]  sw_stable_q, sw_stable_d;
    logic [N_KEY-1:0] key_stable_q, key_stable_d;
    logic [N_KEY-1:0] key_pending_q, key_pending_d;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

    logic [N_KEY-1:0] pend_set, pend_clr;

    // Keys are active-low on the pins; everything past the synchronizer is 1 = pressed.
    assign key_sync = ~key_s2_q;

    always_comb begin
        for (int i = 0; i < N_SW; i++) begin
            sw_cnt_d[i]    = '0;
            sw_stable_d[i] = sw_stable_q[i];
            if (sw_s2_q[i] != sw_stable_q[i]) begin
                if (sw_cnt_q[i] == CNT_LAST) sw_stable_d[i] = sw_s2_q[i];
                else                         sw_cnt_d[i]    = sw_cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_KEY; i++) begin
            key_cnt_d[i]    = '0;
            key_stable_d[i] = key_stable_q[i];
            if (key_sync[i] != key_stable_q[i]) begin
                if (key_cnt_q[i] == CNT_LAST) key_stable_d[i] = key_sync[i];
                else                          key_cnt_d[i]    = key_cnt_q[i] + CW'(1);
            end
        end
    end

    // A read of the pending register clears exactly the bits it returned; a
    // press committing on the same edge still lands.
    always_comb begin
        pend_set      = key_stable_d & ~key_stable_q;
        pend_clr      = (rd_en && rd_addr == 2'd2) ? key_pending_q : '0;
        key_pending_d = (key_pending_q & ~pend_clr) | pend_set;
        chg_cnt_d     = chg_cnt_q + ((sw_stable_d != sw_stable_q) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            key_s1_q      <= '1;
            key_s2_q      <= '1;
            sw_stable_q   <= '0;
            key_stable_q  <= '0;
            key_pending_q <= '0;
            chg_cnt_q     <= '0;
            for (int i = 0; i < N_SW; i++)  sw_cnt_q[i]  <= '0;
            for (int i = 0; i < N_KEY; i++) key_cnt_q[i] <= '0;
        end else begin
            sw_s1_q       <= sw_raw;
            sw_s2_q       <= sw_s1_q;
            key_s1_q      <= key_raw;
            key_s2_q      <= key_s1_q;
            sw_stable_q   <= sw_stable_d;
            key_stable_q  <= key_stable_d;
            key_pending_q <= key_pending_d;
            chg_cnt_q     <= chg_cnt_d;
            for (int i = 0; i < N_SW; i++)  sw_cnt_q[i]  <= sw_cnt_d[i];
            for (int i = 0; i < N_KEY; i++) key_cnt_q[i] <= key_cnt_d[i];
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            2'd0:    rd_data[N_SW-1:0]  = sw_stable_q;
            2'd1:    rd_data[N_KEY-1:0] = key_stable_q;
            2'd2:    rd_data[N_KEY-1:0] = key_pending_q;
            default: rd_data[CNT_W-1:0] = chg_cnt_q;
        endcase
    end

    assign sw_stable   = sw_stable_q;
    assign key_stable  = key_stable_q;
    assign key_pending = key_pending_q;
    assign irq         = |key_pending_q;

endmodule

// File: tb/tb_io_input_debouncer.sv
// Bench for io_input_debouncer: directed scenarios plus randomized toggling,
// checked against a sample-window reference model.
module tb_io_input_debouncer;

    localparam int N_SW  = 10;
    localparam int N_KEY = 3;
    localparam int D     = 4;

    logic             clock;
    logic             resetn;
    logic [N_SW-1:0]  sw_raw;
    logic [N_KEY-1:0] key_raw;
    logic             rd_en;
    logic [1:0]       rd_addr;
    logic [31:0]      rd_data;
    logic [N_SW-1:0]  sw_stable;
    logic [N_KEY-1:0] key_stable;
    logic [N_KEY-1:0] key_pending;
    logic             irq;

    logic        sw2_raw;
    logic [31:0] rd_data2;
    logic        sw2_stable, key2_stable, key2_pending, irq2;

    int n_checks = 0;
    int n_fail   = 0;

    io_input_debouncer #(.N_SW(N_SW), .N_KEY(N_KEY), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .sw_raw(sw_raw), .key_raw(key_raw),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .sw_stable(sw_stable),
        .key_stable(key_stable), .key_pending(key_pending), .irq(irq)
    );

    io_input_debouncer #(.N_SW(1), .N_KEY(1), .DEBOUNCE_CYCLES(D), .CNT_W(2)) dut2 (
        .clock(clock), .resetn(resetn), .sw_raw(sw2_raw), .key_raw(1'b1),
        .rd_en(1'b0), .rd_addr(2'd3), .rd_data(rd_data2), .sw_stable(sw2_stable),
        .key_stable(key2_stable), .key_pending(key2_pending), .irq(irq2)
    );

    // clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: stable flips once the last D synchronized samples all disagree with it
    logic [N_SW-1:0]  sw_hist[$];
    logic [N_KEY-1:0] kp_hist[$];
    logic [N_SW-1:0]  m_sw;
    logic [N_KEY-1:0] m_key;
    logic [N_KEY-1:0] m_pend;
    logic [15:0]      m_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sw_hist.delete();
        kp_hist.delete();
        repeat (D + 2) begin
            sw_hist.push_back('0);
            kp_hist.push_back('0);
        end
        m_sw = '0; m_key = '0; m_pend = '0; m_chg = '0;
    endtask

    function automatic logic [31:0] model_rd();
        case (rd_addr)
            2'd0:    return 32'(m_sw);
            2'd1:    return 32'(m_key);
            2'd2:    return 32'(m_pend);
            default: return 32'(m_chg);
        endcase
    endfunction

    task automatic model_edge();
        logic [N_SW-1:0]  new_sw;
        logic [N_KEY-1:0] new_key, clr;
        bit all_diff;
        sw_hist.push_back(sw_raw);
        kp_hist.push_back(~key_raw);
        void'(sw_hist.pop_front());
        void'(kp_hist.pop_front());
        // entries 0..D-1 are the synchronized values seen on the last D edges
        new_sw = m_sw;
        for (int b = 0; b < N_SW; b++) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++) if (sw_hist[i][b] == m_sw[b]) all_diff = 1'b0;
            if (all_diff) new_sw[b] = ~m_sw[b];
        end
        new_key = m_key;
        for (int b = 0; b < N_KEY; b++) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++) if (kp_hist[i][b] == m_key[b]) all_diff = 1'b0;
            if (all_diff) new_key[b] = ~m_key[b];
        end
        clr    = (rd_en && rd_addr == 2'd2) ? m_pend : '0;
        m_pend = (m_pend & ~clr) | (new_key & ~m_key);
        if (new_sw != m_sw) m_chg = m_chg + 16'd1;
        m_sw  = new_sw;
        m_key = new_key;
    endtask

    // one clock: check combinational read, cross the edge, check registered outputs
    task automatic step();
        #1;
        check("rd_data", rd_data, model_rd());
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("sw_stable", 32'(sw_stable), 32'(m_sw));
        check("key_stable", 32'(key_stable), 32'(m_key));
        check("key_pending", 32'(key_pending), 32'(m_pend));
        check("irq", 32'(irq), 32'(|m_pend));
    endtask

    // called at a falling edge; asserts reset between edges
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check("rst_sw_stable", 32'(sw_stable), 32'd0);
        check("rst_key_stable", 32'(key_stable), 32'd0);
        check("rst_key_pending", 32'(key_pending), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    int sw_hold  [N_SW];
    int key_hold [N_KEY];
    int exp_cnt2;

    initial begin
        resetn = 1'b0; sw_raw = '0; key_raw = '1; rd_en = 1'b0; rd_addr = 2'd0; sw2_raw = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        step();

        // pending bit set, then reset dropped between edges
        key_raw = 3'b101;
        repeat (D + 3) step();
        check("pend_setup", 32'(key_pending), 32'h2);
        rd_addr = 2'd2;
        do_reset();
        key_raw = '1;

        // switch pattern latency: appears on the (D+2)th edge, not before
        sw_raw  = 10'b1010101010;
        rd_addr = 2'd3;
        for (int e = 1; e <= D + 2; e++) begin
            step();
            check("sw_latency", 32'(sw_stable), (e == D + 2) ? 32'h2AA : 32'h0);
        end
        #1 check("chg_cnt_one", rd_data, 32'd1);

        // short key glitch is filtered
        key_raw = 3'b011;
        repeat (D - 1) step();
        key_raw = 3'b111;
        repeat (D + 3) step();
        check("glitch_key_stable", 32'(key_stable), 32'h0);
        check("glitch_pending", 32'(key_pending), 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        // key1 press -> pending, then clear-on-read
        key_raw = 3'b101;
        repeat (D + 2) step();
        check("press_key_stable", 32'(key_stable), 32'h2);
        check("press_pending", 32'(key_pending), 32'h2);
        check("press_irq", 32'(irq), 32'h1);
        rd_en = 1'b1; rd_addr = 2'd2;
        #1 check("pend_read", rd_data, 32'h2);
        step();
        rd_en = 1'b0;
        check("pend_cleared", 32'(key_pending), 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);

        // set wins over clear on the same edge
        key_raw = 3'b111;
        repeat (D + 3) step();
        key_raw = 3'b101;
        repeat (D + 3) step();
        check("pend_setup2", 32'(key_pending), 32'h2);
        key_raw = 3'b100;
        repeat (D + 1) step();
        rd_en = 1'b1; rd_addr = 2'd2;
        #1 check("race_read", rd_data, 32'h2);
        step();
        rd_en = 1'b0;
        check("race_pending", 32'(key_pending), 32'h1);

        // randomized toggling with reads and occasional resets
        for (int i = 0; i < N_SW; i++)  sw_hold[i]  = $urandom_range(1, 9);
        for (int i = 0; i < N_KEY; i++) key_hold[i] = $urandom_range(1, 9);
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N_SW; i++) begin
                sw_hold[i]--;
                if (sw_hold[i] == 0) begin
                    sw_raw[i]  = ~sw_raw[i];
                    sw_hold[i] = $urandom_range(1, 9);
                end
            end
            for (int i = 0; i < N_KEY; i++) begin
                key_hold[i]--;
                if (key_hold[i] == 0) begin
                    key_raw[i]  = ~key_raw[i];
                    key_hold[i] = $urandom_range(1, 9);
                end
            end
            rd_en   = ($urandom_range(0, 3) == 0);
            rd_addr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end
        rd_en = 1'b0;

        // 2-bit change counter wraps
        for (int k = 0; k < 4; k++) begin
            sw2_raw = ~sw2_raw;
            repeat (D + 4) step();
            exp_cnt2 = (k + 1) % 4;
            check("cnt_wrap", rd_data2, 32'(exp_cnt2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_input_debouncer.md
IO_INPUT_DEBOUNCER -- requirements
Module: io_input_debouncer

Interface
REQ-001 Parameter N_SW, default 10: number of slide-switch channels, 1..32.
REQ-002 Parameter N_KEY, default 3: number of push-key channels, 1..32.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive mismatch cycles before a stable update, >=1.
REQ-004 Parameter CNT_W, default 16: switch-change counter width, 1..32.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 sw_raw  input  N_SW  asynchronous switch levels, 1 = on.
REQ-008 key_raw  input  N_KEY  asynchronous key levels, active-low (0 = pressed).
REQ-009 rd_en  input  1  read strobe, sampled at the clock edge.
REQ-010 rd_addr  input  2  read register select.
REQ-011 rd_data  output  32  combinational read data from registered state.
REQ-012 sw_stable  output  N_SW  debounced switch levels.
REQ-013 key_stable  output  N_KEY  debounced key state, 1 = pressed.
REQ-014 key_pending  output  N_KEY  sticky press-event bits.
REQ-015 irq  output  1  OR of key_pending.

Function
REQ-016 Each raw bit SHALL pass through a 2-flop synchronizer before any other logic; key bits are inverted after synchronization.
REQ-017 Each channel SHALL have its own counter: increments on every edge where the synchronized value differs from the stable value; clears to 0 on any edge where they match.
REQ-018 On an edge with a mismatch and counter == DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear.
REQ-019 Latency: a raw change held steady SHALL appear on the stable output at the (DEBOUNCE_CYCLES+2)th rising edge after the change, counting the first edge that samples it.
REQ-020 A raw pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL not change stable outputs.
REQ-021 A key stable transition 0->1 SHALL set the matching key_pending bit; a 1->0 transition SHALL not affect key_pending.
REQ-022 rd_addr 0 SHALL return sw_stable; 1 key_stable; 2 key_pending; 3 the switch-change counter; all zero-extended to 32 bits.
REQ-023 An edge with rd_en=1 and rd_addr=2 SHALL clear the key_pending bits presented on rd_data in that cycle.
REQ-024 If a pending bit is set and cleared on the same edge, set SHALL win.
REQ-025 Switch-change counter SHALL increment by 1 on each edge where any sw_stable bit changes, regardless of how many bits change, and wrap from 2^CNT_W-1 to 0.
REQ-026 Reads of addresses 0, 1 and 3 SHALL have no side effects.
REQ-027 irq SHALL be combinational from key_pending, with no extra delay.

Reset
REQ-028 While resetn=0, independent of clock: synchronizers SHALL hold inactive levels (sw 0, key 1); counters, sw_stable, key_stable, key_pending and the change counter SHALL be 0; irq SHALL be 0.
REQ-029 Reset release SHALL cause no spurious stable transition, pending bit or count while raw inputs are at inactive levels.
REQ-030 Reset asserted mid-debounce or with bits pending SHALL discard all in-progress state.

Verification
REQ-031 Setup: defaults (N_SW=10, N_KEY=3, D=4); key_pending=3'b010; pull resetn low between edges -> all outputs 0 immediately; rd_data at addr 2 = 0.
REQ-032 Setup: after reset, sw_raw=10'b1010101010 held -> sw_stable=0x2AA at 6th edge, not before; addr 3 reads 1.
REQ-033 key_raw[2] driven low for 3 cycles, then high -> key_stable, key_pending and irq remain 0.
REQ-034 key_raw=3'b101 held -> key_stable=3'b010, key_pending=3'b010, irq=1 at 6th edge. Then read addr 2 -> rd_data=0x2; after that edge key_pending=0 and irq=0.
REQ-035 Setup: key_pending=3'b010; key0 stable press commits on the same edge as an addr 2 read -> rd_data=0x2 that cycle; after the edge key_pending=3'b001.
REQ-036 With CNT_W=2, toggle sw_raw[0] steady 4 times -> addr 3 reads 1, 2, 3, 0.
